// File: rtl/oppm_tx_arbiter.sv
// oppm_tx_arbiter
//   Round-robin scheduler that shares a single OPPM Encoder among N_REQ packet
//   sources. The arbiter:
//     1. captures the winning source's packet,
//     2. pulses the Encoder start strobe,
//     3. waits for the Encoder to report avail again,
//     4. holds the optical link idle for a guard gap before the next packet.
//
//   Optional watchdog (compile-time macro OPPM_TXARB_WDOG_EN):
//     - Defined: a stalled Encoder is abandoned after TIMEOUT_CT cycles in
//       WAIT_DONE, and a sticky err flag is raised.
//     - Undefined: err is tied low and WAIT_DONE waits indefinitely.
//
//   All outputs are registered. rst is synchronous and active-high.
module oppm_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int N_PKT      = 16,
    parameter int GAP_CT     = 32,
    parameter int TIMEOUT_CT = 4096,
    localparam int ID_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*N_PKT-1:0] req_data,
    output logic [N_REQ-1:0]       grant,
    output logic [ID_W-1:0]        cur_id,
    output logic                   busy,
    output logic [N_PKT-1:0]       enc_data,
    output logic                   enc_start,
    input  logic                   enc_avail,
    output logic                   err
);

    // FSM encoding
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    // Gap counter sizing; a one-bit counter is kept when the gap is disabled
    // so the declarations stay legal.
    localparam int GAP_W    = (GAP_CT > 0) ? $clog2(GAP_CT + 1) : 1;
    localparam int GAP_LAST = (GAP_CT > 0) ? (GAP_CT - 1) : 0;

    logic [1:0]       state_q,     state_d;
    logic [ID_W-1:0]  ptr_q,       ptr_d;
    logic [N_REQ-1:0] grant_q,     grant_d;
    logic [ID_W-1:0]  cur_id_q,    cur_id_d;
    logic [N_PKT-1:0] enc_data_q,  enc_data_d;
    logic             enc_start_q, enc_start_d;
    logic             busy_q,      busy_d;
    logic [GAP_W-1:0] gap_q,       gap_d;

    // Raised for one cycle when the Encoder is declared stalled.
    logic wdog_expire;

    // ------------------------------------------------------------------
    // Rotated request view
    //   cand_idx[k] = (ptr + k) mod N_REQ, i.e. the k-th source visited
    //                 when the search starts at the pointer.
    //   The wrap is a compare-and-subtract, so non-power-of-2 N_REQ works.
    // ------------------------------------------------------------------
    logic [N_PKT-1:0] src_data [N_REQ];
    logic [ID_W-1:0]  cand_idx [N_REQ];
    logic [N_REQ-1:0] rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_src
            logic [ID_W:0] cand_sum;

            assign src_data[gi] = req_data[gi*N_PKT +: N_PKT];
            assign cand_sum     = {1'b0, ptr_q} + (ID_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum >= (ID_W+1)'(N_REQ))
                                ? ID_W'(cand_sum - (ID_W+1)'(N_REQ))
                                : cand_sum[ID_W-1:0];
            assign rot_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Winner selection: the lowest rotated position with a request set.
    logic [ID_W-1:0] sel_idx;
    logic [ID_W-1:0] sel_ptr_next;

    // Priority-pick the first requester at or after the pointer.
    always_comb begin
        sel_idx = cand_idx[0];
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                sel_idx = cand_idx[k];
            end
        end
    end

    // Pointer advance: one past the winner, wrapped mod N_REQ.
    assign sel_ptr_next = (sel_idx == ID_W'(N_REQ - 1)) ? '0 : (sel_idx + 1'b1);

    // Next-state and output decode for the scheduling FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = '0;
        cur_id_d    = cur_id_q;
        enc_data_d  = enc_data_q;
        enc_start_d = 1'b0;
        gap_d       = gap_q;

        case (state_q)
            S_IDLE: begin
                // Only launch when the Encoder is idle; otherwise the
                // request is simply left pending.
                if ((|req) && enc_avail) begin
                    enc_data_d  = src_data[sel_idx];
                    cur_id_d    = sel_idx;
                    ptr_d       = sel_ptr_next;
                    grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    enc_start_d = 1'b1;
                    state_d     = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                // enc_avail is deliberately ignored here: the Encoder only
                // drops avail one cycle after it sees the start strobe.
                state_d = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                if (enc_avail || wdog_expire) begin
                    if (GAP_CT > 0) begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cur_id_q    <= '0;
            enc_data_q  <= '0;
            enc_start_q <= 1'b0;
            busy_q      <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cur_id_q    <= cur_id_d;
            enc_data_q  <= enc_data_d;
            enc_start_q <= enc_start_d;
            busy_q      <= busy_d;
            gap_q       <= gap_d;
        end
    end

`ifdef OPPM_TXARB_WDOG_EN
    // ------------------------------------------------------------------
    // Watchdog on the Encoder's completion
    //   - Counts WAIT_DONE cycles with enc_avail low.
    //   - Cleared while in LAUNCH, i.e. on every entry to WAIT_DONE.
    //   - Expires on the TIMEOUT_CT-th such cycle.
    // ------------------------------------------------------------------
    localparam int WDOG_W = $clog2(TIMEOUT_CT + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q,  err_d;

    assign wdog_expire = (state_q == S_WAIT_DONE) && !enc_avail
                      && (wdog_q == WDOG_W'(TIMEOUT_CT - 1));

    // Watchdog count and sticky error next-state.
    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_q;
        if (state_q == S_LAUNCH) begin
            wdog_d = '0;
        end else if ((state_q == S_WAIT_DONE) && !enc_avail && !wdog_expire) begin
            wdog_d = wdog_q + 1'b1;
        end
        if (wdog_expire) begin
            err_d = 1'b1;
        end
    end

    // Watchdog registers; err is only cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wdog_expire = 1'b0;
    assign err         = 1'b0;
`endif

    assign grant     = grant_q;
    assign cur_id    = cur_id_q;
    assign busy      = busy_q;
    assign enc_data  = enc_data_q;
    assign enc_start = enc_start_q;

endmodule

// File: tb/tb_oppm_tx_arbiter.sv
// tb_oppm_tx_arbiter
//   Directed bench for oppm_tx_arbiter.
//   The bench contains a small Encoder model:
//     - avail drops on the edge that samples enc_start,
//     - stays low for enc_low cycles (forever while enc_stuck is set),
//     - then rises again.
//   force_low masks avail to emulate a busy Encoder while the arbiter is idle.
`timescale 1ns/1ps
module tb_oppm_tx_arbiter;

    localparam int N_REQ  = 4;
    localparam int N_PKT  = 16;
    localparam int GAP_CT = 32;
`ifdef OPPM_TXARB_WDOG_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 4096;
`endif
    localparam int L_SHORT = 5;
    // grant-to-grant spacing with req held:
    //   LAUNCH + L low cycles + avail-high WAIT cycle + GAP + IDLE
    localparam int RR_PERIOD = 1 + L_SHORT + 1 + GAP_CT + 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*N_PKT-1:0] req_data;
    logic [N_REQ-1:0]       grant;
    logic [1:0]             cur_id;
    logic                   busy;
    logic [N_PKT-1:0]       enc_data;
    logic                   enc_start;
    logic                   enc_avail;
    logic                   err;

    logic [N_PKT-1:0] src_val [N_REQ];

    int n_checks = 0;
    int n_fail   = 0;

    // Encoder model state
    logic enc_av_q;
    int   enc_cnt_q;
    int   enc_low   = L_SHORT;
    bit   enc_stuck = 1'b0;
    bit   force_low = 1'b0;

    always #5 clk = ~clk;

    oppm_tx_arbiter #(
        .N_REQ(N_REQ), .N_PKT(N_PKT), .GAP_CT(GAP_CT), .TIMEOUT_CT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .cur_id(cur_id), .busy(busy), .enc_data(enc_data),
        .enc_start(enc_start), .enc_avail(enc_avail), .err(err)
    );

    // Encoder model: avail low for enc_low cycles after each start strobe.
    always @(posedge clk) begin
        if (rst) begin
            enc_av_q  <= 1'b1;
            enc_cnt_q <= 0;
        end else if (enc_start) begin
            enc_av_q  <= 1'b0;
            enc_cnt_q <= enc_low;
        end else if (!enc_av_q && !enc_stuck) begin
            if (enc_cnt_q <= 1) enc_av_q <= 1'b1;
            else                enc_cnt_q <= enc_cnt_q - 1;
        end
    end
    assign enc_avail = enc_av_q & ~force_low;

    // Source packets
    initial begin
        src_val[0] = 16'h1111;
        src_val[1] = 16'h2222;
        src_val[2] = 16'hA5C3;
        src_val[3] = 16'h4444;
    end
    always_comb begin
        for (int i = 0; i < N_REQ; i++) req_data[i*N_PKT +: N_PKT] = src_val[i];
    end

    // Advance one cycle; sample/drive 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        ok = !busy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        enc_stuck = 1'b0;
        force_low = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'hF;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (grant !== 4'b0000 || enc_start !== 1'b0 || busy !== 1'b0 || cur_id !== 2'd0
                || err !== 1'b0 || enc_data !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_outputs: got grant=%b start=%b busy=%b id=%0d err=%b data=%h, expected all zero",
                         grant, enc_start, busy, cur_id, err, enc_data);
            end
        end
        req = '0;
        rst = 1'b0;
        step();
        $display("reset: outputs checked over 2 reset cycles");
    endtask

    task automatic test_single();
        int  busy_cycles;
        int  k;
        bit  ok;
        enc_low = 100;
        req = 4'b0100;
        step();
        n_checks++;
        if (grant !== 4'b0100 || enc_start !== 1'b1 || enc_data !== 16'hA5C3 || cur_id !== 2'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got grant=%b start=%b data=%h id=%0d busy=%b, expected 0100 1 a5c3 2 1",
                     grant, enc_start, enc_data, cur_id, busy);
        end
        req = '0;
        busy_cycles = 1;
        k = 0;
        while (k < 1000) begin
            step();
            k++;
            if (k == 1) begin
                n_checks++;
                if (grant !== 4'b0000 || enc_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_pulse_width: got grant=%b start=%b, expected 0000 0", grant, enc_start);
                end
            end
            if (!busy) break;
            busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != 1 + 100 + 1 + GAP_CT) begin
            n_fail++;
            $display("FAIL single_busy_len: got %0d cycles, expected %0d", busy_cycles, 1 + 100 + 1 + GAP_CT);
        end
        n_checks++;
        if (enc_data !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL single_data_hold: got %h, expected a5c3", enc_data);
        end
        wait_idle(10, ok);
        enc_low = L_SHORT;
        $display("single: source 2 granted, busy for %0d cycles", busy_cycles);
    endtask

    task automatic test_round_robin();
        int exp_order [5];
        int waited;
        int exp_wait;
        bit ok;
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            do begin
                step();
                waited++;
            end while (grant === 4'b0000 && waited < 200);
            exp_wait = (g == 0) ? 1 : RR_PERIOD;
            n_checks++;
            if (grant !== (4'b0001 << exp_order[g]) || cur_id !== 2'(exp_order[g])
                || enc_data !== src_val[exp_order[g]]) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got grant=%b id=%0d data=%h, expected source %0d",
                         g, grant, cur_id, enc_data, exp_order[g]);
            end
            n_checks++;
            if (waited != exp_wait) begin
                n_fail++;
                $display("FAIL rr_spacing%0d: got %0d cycles, expected %0d", g, waited, exp_wait);
            end
            $display("round_robin: grant %0d -> source %0d after %0d cycles", g, cur_id, waited);
        end
        req = '0;
        wait_idle(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rr_idle: got busy=%b, expected 0 within budget", busy);
        end
    endtask

    task automatic test_blocked();
        force_low = 1'b1;
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (grant !== 4'b0000 || enc_start !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL blocked_no_grant: got grant=%b start=%b busy=%b, expected 0000 0 0",
                         grant, enc_start, busy);
            end
        end
        force_low = 1'b0;
        step();
        n_checks++;
        if (grant !== 4'b0001 || enc_start !== 1'b1) begin
            n_fail++;
            $display("FAIL blocked_release: got grant=%b start=%b, expected 0001 1", grant, enc_start);
        end
        req = '0;
        $display("blocked: grant=%b one cycle after avail returned", grant);
    endtask

    task automatic test_holdoff();
        bit ok;
        wait_idle(200, ok);
        // pointer is now 1, so a latched req[1] would beat req[3]
        req = 4'b0001;
        step();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL holdoff_first: got grant=%b, expected 0001", grant);
        end
        req = '0;
        for (int off = 1; off <= RR_PERIOD; off++) begin
            step();
            req[1] = (off >= 10 && off <= 12);
            req[3] = (off >= 10);
            if (off < RR_PERIOD) begin
                n_checks++;
                if (grant !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL holdoff_early: got grant=%b at offset %0d, expected 0000", grant, off);
                end
            end else begin
                n_checks++;
                if (grant !== 4'b1000 || cur_id !== 2'd3) begin
                    n_fail++;
                    $display("FAIL holdoff_grant3: got grant=%b id=%0d, expected 1000 3", grant, cur_id);
                end
            end
        end
        req = '0;
        for (int c = 0; c < 60; c++) begin
            step();
            n_checks++;
            if (grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL holdoff_lost_req1: got grant=%b, expected 0000", grant);
            end
        end
        $display("holdoff: pulsed req[1] ignored, held req[3] granted at offset %0d", RR_PERIOD);
    endtask

    task automatic test_watchdog();
        bit ok;
        wait_idle(200, ok);
        enc_stuck = 1'b1;
        req = 4'b0001;
        step();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL wdog_grant: got grant=%b, expected 0001", grant);
        end
        req = '0;
`ifdef OPPM_TXARB_WDOG_EN
        for (int off = 1; off <= 9 + GAP_CT; off++) begin
            step();
            if (off == 8) begin
                n_checks++;
                if (err !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wdog_early: got err=%b busy=%b, expected 0 1", err, busy);
                end
            end
            if (off == 9) begin
                n_checks++;
                if (err !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wdog_fire: got err=%b busy=%b, expected 1 1", err, busy);
                end
            end
            if (off == 8 + GAP_CT) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wdog_gap: got busy=%b, expected 1", busy);
                end
            end
            if (off == 9 + GAP_CT) begin
                n_checks++;
                if (busy !== 1'b0 || err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wdog_idle: got busy=%b err=%b, expected 0 1", busy, err);
                end
            end
        end
        for (int c = 0; c < 5; c++) step();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_sticky: got err=%b, expected 1", err);
        end
        $display("watchdog: err raised after %0d stalled cycles", TB_TIMEOUT);
`else
        for (int c = 0; c < 300; c++) step();
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_wait: got busy=%b err=%b, expected 1 0", busy, err);
        end
        $display("stall: arbiter still waiting after 300 cycles, err=%b", err);
`endif
        do_reset();
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL stall_reset: got busy=%b err=%b grant=%b, expected 0 0 0000", busy, err, grant);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_blocked();
        test_holdoff();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
